// File: rtl/gen3_framing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gen3_framing_pkg
// Purpose : Shared definitions for the Gen3 128b/130b framing parser. Holds
//           the token encodings, the sync header codes, the parser mode enum
//           and the per-byte state/flag structures passed along the byte chain.
// Ports   : none (package)
// Rev     : 1.0  initial parametrised release
// ============================================================================
package gen3_framing_pkg;

  // Framing token encodings
  localparam logic [3:0] c_stp_nib  = 4'hF;
  localparam logic [7:0] c_sdp_b0   = 8'hF0;
  localparam logic [7:0] c_sdp_b1   = 8'h53;
  localparam logic [7:0] c_edb      = 8'hC0;
  localparam logic [7:0] c_idl      = 8'h00;

  // Sync header codes
  localparam logic [1:0] c_sh_data  = 2'b10;
  localparam logic [1:0] c_sh_os    = 2'b01;

  // SDP token plus DLLP body, in bytes
  localparam int unsigned c_dllp_len = 8;

  // Width of the remaining-byte counter (11-bit DW length, times 4)
  localparam int unsigned c_rem_w = 13;

  typedef enum logic [2:0] {
    MODE_IDLE     = 3'd0,
    MODE_IN_TLP   = 3'd1,
    MODE_IN_DLP   = 3'd2,
    MODE_PEND_STP = 3'd3,
    MODE_PEND_SDP = 3'd4,
    MODE_ERR      = 3'd5
  } mode_e;

  // State carried from byte to byte and from beat to beat.
  // edb_cnt counts the EDB token bytes still to be consumed after its first byte.
  typedef struct packed {
    mode_e              mode;
    logic [c_rem_w-1:0] rem;
    logic [3:0]         stp_nib;
    logic [1:0]         edb_cnt;
  } parse_state_t;

  typedef struct packed {
    logic tlpstart;
    logic tlpend;
    logic tlpedb;
    logic dlpstart;
    logic dlpend;
    logic err;
  } byte_flags_t;

endpackage : gen3_framing_pkg
`default_nettype wire

// File: rtl/gen3_byte_step.sv
`default_nettype none
// ============================================================================
// Module  : gen3_byte_step
// Purpose : Combinational single-byte framing state transition. Given the
//           parser state entering a byte, the byte, its qualifier and its sync
//           header, produces the state leaving the byte and the byte's flags.
// Ports   : cur_i    - state entering this byte
//           byte_i   - byte value
//           valid_i  - byte qualifier (0 = byte skipped, state passes through)
//           sh_i     - 2-bit sync header for this byte
//           nxt_o    - state leaving this byte
//           flags_o  - boundary / error flags for this byte
// Rev     : 1.0  initial parametrised release
// ============================================================================
module gen3_byte_step
  import gen3_framing_pkg::*;
#(
  parameter int unsigned MAX_TLP_DW = 1024
) (
  input  parse_state_t cur_i,
  input  logic [7:0]   byte_i,
  input  logic         valid_i,
  input  logic [1:0]   sh_i,
  output parse_state_t nxt_o,
  output byte_flags_t  flags_o
);

  // STP length in DW: low nibble came with the first token byte
  logic [10:0]        w_len;
  logic [c_rem_w-1:0] w_tlp_rem;
  logic               w_len_bad;

  assign w_len     = {byte_i[6:0], cur_i.stp_nib};
  // Two token bytes are already consumed when the length becomes known
  assign w_tlp_rem = {w_len, 2'b00} - c_rem_w'(2);
  assign w_len_bad = (w_len < 11'd2) || ({21'd0, w_len} > MAX_TLP_DW);

  always_comb begin
    nxt_o   = cur_i;
    flags_o = '0;
    if (valid_i) begin
      if (sh_i == c_sh_os) begin
        // Ordered set: resynchronisation point; only legal between packets
        if (cur_i.mode != MODE_IDLE && cur_i.mode != MODE_ERR) begin
          flags_o.err = 1'b1;
        end
        nxt_o.mode    = MODE_IDLE;
        nxt_o.rem     = '0;
        nxt_o.edb_cnt = '0;
      end else if (sh_i != c_sh_data) begin
        flags_o.err   = 1'b1;
        nxt_o.mode    = MODE_ERR;
        nxt_o.rem     = '0;
        nxt_o.edb_cnt = '0;
      end else begin
        case (cur_i.mode)
          MODE_IDLE: begin
            if (cur_i.edb_cnt != 2'd0) begin
              // Tail of an EDB token: every byte must repeat the EDB code
              if (byte_i != c_edb) begin
                flags_o.err = 1'b1;
              end
              nxt_o.edb_cnt = cur_i.edb_cnt - 2'd1;
            end else if (byte_i == c_idl) begin
              nxt_o = cur_i;
            end else if (byte_i[3:0] == c_stp_nib) begin
              flags_o.tlpstart = 1'b1;
              nxt_o.stp_nib    = byte_i[7:4];
              nxt_o.mode       = MODE_PEND_STP;
            end else if (byte_i == c_sdp_b0) begin
              flags_o.dlpstart = 1'b1;
              nxt_o.mode       = MODE_PEND_SDP;
            end else if (byte_i == c_edb) begin
              flags_o.tlpedb = 1'b1;
              nxt_o.edb_cnt  = 2'd3;
            end else begin
              flags_o.err = 1'b1;
              nxt_o.mode  = MODE_ERR;
            end
          end
          MODE_PEND_STP: begin
            if (w_len_bad) begin
              flags_o.err = 1'b1;
              nxt_o.mode  = MODE_ERR;
            end else begin
              nxt_o.rem  = w_tlp_rem;
              nxt_o.mode = MODE_IN_TLP;
            end
          end
          MODE_PEND_SDP: begin
            if (byte_i != c_sdp_b1) begin
              flags_o.err = 1'b1;
              nxt_o.mode  = MODE_ERR;
            end else begin
              nxt_o.rem  = c_rem_w'(c_dllp_len - 2);
              nxt_o.mode = MODE_IN_DLP;
            end
          end
          MODE_IN_TLP, MODE_IN_DLP: begin
            if (cur_i.rem == c_rem_w'(1)) begin
              flags_o.tlpend = (cur_i.mode == MODE_IN_TLP);
              flags_o.dlpend = (cur_i.mode == MODE_IN_DLP);
              nxt_o.mode     = MODE_IDLE;
              nxt_o.rem      = '0;
            end else begin
              nxt_o.rem = cur_i.rem - c_rem_w'(1);
            end
          end
          default: begin
            // MODE_ERR: data bytes ignored until an ordered set arrives
            nxt_o = cur_i;
          end
        endcase
      end
    end
  end

endmodule : gen3_byte_step
`default_nettype wire

// File: rtl/gen3_framing_parser.sv
`default_nettype none
// ============================================================================
// Module  : gen3_framing_parser
// Purpose : Parses 128b/130b framing tokens (STP, SDP, EDB, IDL) on a
//           BYTES-wide per-byte-qualified stream and marks TLP/DLLP
//           boundaries per byte, with one cycle of latency. Packet and token
//           state carries across beats; framing errors park the parser until
//           an ordered-set byte resynchronises it.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           data_in       - beat data, byte i = data_in[8i+7:8i]
//           valid         - per-byte qualifier
//           sync_header   - 2 bits per byte: 10 data, 01 ordered set
//           data_out      - data_in delayed one cycle
//           valid_d       - valid delayed one cycle
//           tlpstart      - first byte of STP token
//           tlpend        - last byte of TLP
//           tlpedb        - first byte of EDB token
//           dlpstart      - first byte of SDP token
//           dlpend        - last (8th) byte of SDP+DLLP
//           framing_err   - one pulse per beat containing any framing error
// Rev     : 1.0  initial parametrised release
// ============================================================================
module gen3_framing_parser
  import gen3_framing_pkg::*;
#(
  parameter int unsigned BYTES      = 64,
  parameter int unsigned MAX_TLP_DW = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*BYTES-1:0]   data_in,
  input  logic [BYTES-1:0]     valid,
  input  logic [2*BYTES-1:0]   sync_header,
  output logic [8*BYTES-1:0]   data_out,
  output logic [BYTES-1:0]     valid_d,
  output logic [BYTES-1:0]     tlpstart,
  output logic [BYTES-1:0]     tlpend,
  output logic [BYTES-1:0]     tlpedb,
  output logic [BYTES-1:0]     dlpstart,
  output logic [BYTES-1:0]     dlpend,
  output logic                 framing_err
);

  parse_state_t       state_q;
  parse_state_t       state_d;

  logic [BYTES-1:0]   w_tlpstart;
  logic [BYTES-1:0]   w_tlpend;
  logic [BYTES-1:0]   w_tlpedb;
  logic [BYTES-1:0]   w_dlpstart;
  logic [BYTES-1:0]   w_dlpend;
  logic [BYTES-1:0]   w_err;

  // Byte chain: each stage consumes the state left by the previous byte
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
    parse_state_t w_cur;
    parse_state_t w_nxt;
    byte_flags_t  w_flags;

    if (gi == 0) begin : g_first
      assign w_cur = state_q;
    end else begin : g_rest
      assign w_cur = g_byte[gi-1].w_nxt;
    end

    gen3_byte_step #(
      .MAX_TLP_DW (MAX_TLP_DW)
    ) u_step (
      .cur_i   (w_cur),
      .byte_i  (data_in[8*gi +: 8]),
      .valid_i (valid[gi]),
      .sh_i    (sync_header[2*gi +: 2]),
      .nxt_o   (w_nxt),
      .flags_o (w_flags)
    );

    assign w_tlpstart[gi] = w_flags.tlpstart;
    assign w_tlpend[gi]   = w_flags.tlpend;
    assign w_tlpedb[gi]   = w_flags.tlpedb;
    assign w_dlpstart[gi] = w_flags.dlpstart;
    assign w_dlpend[gi]   = w_flags.dlpend;
    assign w_err[gi]      = w_flags.err;
  end

  assign state_d = g_byte[BYTES-1].w_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= '0;
      data_out    <= '0;
      valid_d     <= '0;
      tlpstart    <= '0;
      tlpend      <= '0;
      tlpedb      <= '0;
      dlpstart    <= '0;
      dlpend      <= '0;
      framing_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out    <= data_in;
      valid_d     <= valid;
      tlpstart    <= w_tlpstart;
      tlpend      <= w_tlpend;
      tlpedb      <= w_tlpedb;
      dlpstart    <= w_dlpstart;
      dlpend      <= w_dlpend;
      framing_err <= |w_err;
    end
  end

endmodule : gen3_framing_parser
`default_nettype wire

// File: tb/tb_gen3_framing_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_gen3_framing_parser
// Purpose : Directed self-checking bench for gen3_framing_parser, BYTES=64.
// Rev     : 1.0
// ============================================================================
module tb_gen3_framing_parser;

  localparam int unsigned BYTES = 64;

  logic               clk;
  logic               rst;
  logic [8*BYTES-1:0] data_in;
  logic [BYTES-1:0]   valid;
  logic [2*BYTES-1:0] sync_header;
  logic [8*BYTES-1:0] data_out;
  logic [BYTES-1:0]   valid_d;
  logic [BYTES-1:0]   tlpstart;
  logic [BYTES-1:0]   tlpend;
  logic [BYTES-1:0]   tlpedb;
  logic [BYTES-1:0]   dlpstart;
  logic [BYTES-1:0]   dlpend;
  logic               framing_err;

  int n_total = 0;
  int n_bad   = 0;

  gen3_framing_parser #(
    .BYTES      (BYTES),
    .MAX_TLP_DW (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid       (valid),
    .sync_header (sync_header),
    .data_out    (data_out),
    .valid_d     (valid_d),
    .tlpstart    (tlpstart),
    .tlpend      (tlpend),
    .tlpedb      (tlpedb),
    .dlpstart    (dlpstart),
    .dlpend      (dlpend),
    .framing_err (framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bit1(input int i);
    return 64'd1 << i;
  endfunction

  // Default beat: all bytes IDL, all valid, all data sync headers
  task automatic clr_beat();
    data_in     = '0;
    valid       = '1;
    sync_header = {BYTES{2'b10}};
  endtask

  task automatic set_b(input int i, input logic [7:0] b);
    data_in[8*i +: 8] = b;
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] b);
    for (int i = lo; i <= hi; i++) data_in[8*i +: 8] = b;
  endtask

  // Launch the current beat; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr_beat();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_tlpstart", tlpstart, 64'd0);
    chk("rst_tlpend",   tlpend,   64'd0);
    chk("rst_dlpstart", dlpstart, 64'd0);
    chk("rst_valid_d",  valid_d,  64'd0);
    chk("rst_err",      {63'd0, framing_err}, 64'd0);
    rst = 1'b0;

    // STP len 4 DW in a single beat
    clr_beat();
    set_b(0, 8'h4F); set_b(1, 8'h00); fill(2, 15, 8'hAA);
    step();
    chk("stp_start",  tlpstart, bit1(0));
    chk("stp_end",    tlpend,   bit1(15));
    chk("stp_err",    {63'd0, framing_err}, 64'd0);
    chk("stp_dout",   data_out[63:0], 64'hAAAA_AAAA_AAAA_004F);
    chk("stp_validd", valid_d, 64'hFFFF_FFFF_FFFF_FFFF);

    // Two back-to-back SDPs
    clr_beat();
    set_b(0, 8'hF0); set_b(1, 8'h53); fill(2, 7, 8'hAA);
    set_b(8, 8'hF0); set_b(9, 8'h53); fill(10, 15, 8'hAA);
    step();
    chk("sdp_start", dlpstart, bit1(0) | bit1(8));
    chk("sdp_end",   dlpend,   bit1(7) | bit1(15));
    chk("sdp_err",   {63'd0, framing_err}, 64'd0);

    // TLP of 32 DW starting at byte 62, ending at beat2 byte 61
    clr_beat();
    set_b(62, 8'h0F); set_b(63, 8'h02);
    step();
    chk("xb0_start", tlpstart, bit1(62));
    chk("xb0_end",   tlpend,   64'd0);
    clr_beat();
    fill(0, 63, 8'hAA);
    step();
    chk("xb1_start", tlpstart, 64'd0);
    chk("xb1_end",   tlpend,   64'd0);
    chk("xb1_err",   {63'd0, framing_err}, 64'd0);
    clr_beat();
    fill(0, 61, 8'hAA);
    step();
    chk("xb2_end",   tlpend,   bit1(61));
    chk("xb2_err",   {63'd0, framing_err}, 64'd0);

    // Split STP token with length 1 -> error, ignore until ordered set
    clr_beat();
    set_b(63, 8'h1F);
    step();
    chk("spl0_start", tlpstart, bit1(63));
    chk("spl0_err",   {63'd0, framing_err}, 64'd0);
    clr_beat();
    fill(1, 63, 8'hAA);
    step();
    chk("spl1_err",   {63'd0, framing_err}, 64'd1);
    clr_beat();
    fill(0, 63, 8'h4F);
    step();
    chk("spl2_err",   {63'd0, framing_err}, 64'd0);
    chk("spl2_start", tlpstart, 64'd0);
    clr_beat();
    sync_header[1:0] = 2'b01;
    set_b(1, 8'h4F); set_b(2, 8'h00); fill(3, 16, 8'hAA);
    step();
    chk("spl3_start", tlpstart, bit1(1));
    chk("spl3_end",   tlpend,   bit1(16));
    chk("spl3_err",   {63'd0, framing_err}, 64'd0);

    // EDB token, good then corrupted
    clr_beat();
    fill(0, 3, 8'hC0);
    step();
    chk("edb_flag",  tlpedb,   bit1(0));
    chk("edb_start", tlpstart, 64'd0);
    chk("edb_err",   {63'd0, framing_err}, 64'd0);
    clr_beat();
    set_b(0, 8'hC0); set_b(1, 8'hC0); set_b(2, 8'h12); set_b(3, 8'hC0);
    step();
    chk("edbx_flag", tlpedb, bit1(0));
    chk("edbx_err",  {63'd0, framing_err}, 64'd1);

    // Invalid sync header, then recovery on ordered set
    clr_beat();
    sync_header[1:0] = 2'b11;
    step();
    chk("sh_err", {63'd0, framing_err}, 64'd1);
    clr_beat();
    sync_header[1:0] = 2'b01;
    step();
    chk("sh_rec_err", {63'd0, framing_err}, 64'd0);

    // Ordered set in the middle of a TLP
    clr_beat();
    set_b(0, 8'h4F); set_b(1, 8'h00); fill(2, 5, 8'hAA);
    sync_header[11:10] = 2'b01;
    step();
    chk("osmid_err", {63'd0, framing_err}, 64'd1);
    chk("osmid_end", tlpend, 64'd0);

    // Partially valid beat: 4 valid bytes, TLP continues next beat
    clr_beat();
    fill(0, 63, 8'hAA);
    set_b(0, 8'h4F); set_b(1, 8'h00);
    valid = 64'h0F;
    step();
    chk("pv_start",  tlpstart, bit1(0));
    chk("pv_validd", valid_d,  64'h0F);
    chk("pv_err",    {63'd0, framing_err}, 64'd0);
    clr_beat();
    fill(0, 11, 8'hAA);
    step();
    chk("pv_end",    tlpend, bit1(11));
    chk("pv_err2",   {63'd0, framing_err}, 64'd0);

    // Reset asserted in the middle of a long TLP
    clr_beat();
    fill(0, 63, 8'hAA);
    set_b(0, 8'h4F); set_b(1, 8'h04);
    step();
    chk("mr_start", tlpstart, bit1(0));
    #1;
    rst = 1'b1;
    #1;
    chk("mr_start0", tlpstart, 64'd0);
    chk("mr_validd", valid_d,  64'd0);
    chk("mr_dout",   data_out[63:0], 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_beat();
    set_b(0, 8'h4F); set_b(1, 8'h00); fill(2, 15, 8'hAA);
    step();
    chk("mr_new_start", tlpstart, bit1(0));
    chk("mr_new_end",   tlpend,   bit1(15));
    chk("mr_new_err",   {63'd0, framing_err}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_gen3_framing_parser
`default_nettype wire

// File: doc/gen3_framing_parser.md
Name: gen3_framing_parser

Overview:
- Parametrised successor of the fixed 64-byte Gen3 data path.
- Parses 128b/130b framing tokens (STP, SDP, EDB, IDL) on a BYTES-wide per-byte-qualified stream and flags TLP/DLLP boundaries per byte.
- Tracks packets, and tokens, that span beats; detects framing errors and re-syncs on an ordered-set block.
- Sits between the lane deskew/descrambler and the TLP/DLLP extractors.

Parameters:
- BYTES, 64, bytes per beat (power of 2, 4..64).
- MAX_TLP_DW, 1024, largest legal STP length in DW (token included); larger lengths are a framing error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- data_in  in  8*BYTES  byte i = data_in[8i+7:8i]
- valid  in  BYTES  per-byte qualifier
- sync_header  in  2*BYTES  sync_header[2i+1:2i] classifies byte i: 2'b10 data, 2'b01 ordered set, other = invalid
- data_out  out  8*BYTES  data_in delayed 1 cycle
- valid_d  out  BYTES  valid delayed 1 cycle
- tlpstart  out  BYTES  first byte of STP token
- tlpend  out  BYTES  last byte of TLP (STP length)
- tlpedb  out  BYTES  first byte of EDB token
- dlpstart  out  BYTES  first byte of SDP
- dlpend  out  BYTES  8th byte of SDP+DLLP
- framing_err  out  1  one-cycle pulse, aligned with the beat carrying the error

Behaviour:
- Reset: every output and all state go to 0; state = IDLE.
- Latency: exactly 1 cycle. Flags are aligned to data_out/valid_d.
- Per beat, bytes are walked in order 0..BYTES-1. Bytes with valid=0 are skipped: no state change, no flags.
- Carried state: mode in {IDLE, IN_TLP, IN_DLP, PEND_STP, PEND_SDP, ERR}; rem = remaining packet bytes (11+2 bits); stp_nib = 4 bits.
- Byte with sync_header 2'b01:
  - IDLE or ERR: return to IDLE.
  - Any other mode: framing_err, then IDLE.
- Byte with an invalid sync_header: framing_err, then ERR.
- IDLE, data byte:
  - 8'h00 (IDL): skip.
  - byte[3:0]==4'hF: tlpstart; stp_nib = byte[7:4]; go to PEND_STP.
  - 8'hF0: dlpstart; go to PEND_SDP.
  - 8'hC0: tlpedb; skip the next 3 bytes. Each of them must be 8'hC0, otherwise framing_err.
  - Anything else: framing_err, then ERR.
- PEND_STP:
  - len = {byte[6:0], stp_nib} DW.
  - len < 2 or len > MAX_TLP_DW: framing_err, then ERR.
  - Otherwise rem = 4*len - 2; go to IN_TLP.
- PEND_SDP:
  - byte must be 8'h53, otherwise framing_err, then ERR.
  - rem = 6; go to IN_DLP.
- IN_TLP / IN_DLP: each valid byte decrements rem. When rem reaches 1, set tlpend/dlpend on that byte and return to IDLE.
- Tokens split across beats (PEND_*, EDB remainder) and packets spanning beats resume in the next beat.
- ERR: every data byte is ignored until an ordered-set byte is seen.
- Several packets may start and end within one beat. A tlpend and the next tlpstart may sit on adjacent bytes.
- framing_err pulses once per beat even if several errors occur in that beat.
- Reset mid-packet: state clears immediately; no end flag is emitted.

Decomposition:
- Shared package gen3_framing_pkg holds:
  - token constants: STP nibble 4'hF, SDP 8'hF0/8'h53, EDB 8'hC0, IDL 8'h00;
  - sync header codes 2'b10/2'b01;
  - the mode enum;
  - DLLP length 8.
- One natural sub-module, gen3_byte_step: combinational per-byte state transition (mode, rem, stp_nib, flags). It is chained BYTES times via generate; the top registers the final state and the outputs.

Test Plan:
- STP single beat, BYTES=64: byte0=8'h4F, byte1=8'h00 (len 4 DW), rest data, all valid, sync 2'b10 -> cycle+1: tlpstart[0]=1, tlpend[15]=1, no error.
- SDP: bytes0/1 = F0,53 -> dlpstart[0]=1, dlpend[7]=1; a second SDP at byte8 -> dlpstart[8]=1, dlpend[15]=1.
- Cross-beat TLP: STP at byte62 with len 32 DW -> tlpstart[62] in beat0; tlpend[61] in beat2 (128 bytes total); no flags in beat1.
- Split token: byte63 = 8'h1F, next beat byte0 = 8'h00 -> len 1 -> framing_err pulse in beat1; stream ignored until an ordered-set byte, then a new STP parses correctly.
- EDB: bytes0-3 = C0 -> tlpedb[0]=1 only; bytes0-3 = C0,C0,12,C0 -> framing_err=1.
- Invalid bytes: valid=64'h0F (4 valid) carrying an STP start -> tlpstart[0]; the packet continues with byte0 of the next beat; reset asserted mid-packet -> all outputs 0 the same cycle.
